jtpang_eeprom: RTL



---
 rtl/jtpang_eeprom_if.sv | 24 ++
 rtl/jtpang_eeprom.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jtpang_eeprom_if.sv
// Three-wire serial EEPROM port plus byte-wide NVRAM dump/restore port.
// The CPU/framework side is the master, the EEPROM model is the slave.
interface jtpang_eeprom_if #(
  parameter int AW = 6
);
  logic         cs;
  logic         sclk;
  logic         sdi;
  logic         sdo;
  logic [AW:0]  prog_addr;
  logic [7:0]   prog_data;
  logic         prog_we;
  logic [7:0]   prog_din;

  modport master (
    output cs, sclk, sdi, prog_addr, prog_data, prog_we,
    input  sdo, prog_din
  );

  modport slave (
    input  cs, sclk, sdi, prog_addr, prog_data, prog_we,
    output sdo, prog_din
  );
endinterface

// File: rtl/jtpang_eeprom.sv
// 93C46-style serial EEPROM responder, 16-bit organisation (2^AW words).
// Decodes start bit / opcode / address on sclk rising edges, serves
// sequential reads, commits WRITE/ERASE/WRAL/ERAL on cs fall when write
// enabled, and exposes the array as NVRAM through a byte-wide port.
// Optional feature macro: JTPANG_EEPROM_BUSY_EN enables ready/busy modelling
// (sdo low for BUSY_CYCLES clocks after a commit); without it commits are
// invisible on sdo and BUSY_CYCLES is unused.
module jtpang_eeprom #(
  parameter int          AW          = 6,
  parameter logic [15:0] BUSY_CYCLES = 16'd500
) (
  input  logic            clk,
  input  logic            rst_n,
  jtpang_eeprom_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CMD, RDATA, WDATA, WAIT_CS} state_t;

  localparam logic [4:0]    CMD_LAST = 5'(AW + 1);
  localparam logic [AW-1:0] ADDR_MAX = '1;

  logic [15:0]   mem [0:(2**AW)-1];

  state_t        st_q;
  logic          sclk_l_q;
  logic          sclk_rise;
  logic [AW:0]   cmd_q;
  logic [AW+1:0] cmd_d;
  logic [4:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   data_q;
  logic          pend_q;
  logic          all_q;
  logic          wen_q;
  logic          sdo_q;
  logic [15:0]   rd_word;
  logic          commit;
  logic          busy;

  logic          wr_q;
  logic          wr_all_q;
  logic [AW-1:0] wr_addr_q;
  logic [15:0]   wr_data_q;
  logic [7:0]    prog_din_q;

  assign sclk_rise = ~sclk_l_q & bus.sclk;
  assign cmd_d     = {cmd_q, bus.sdi};
  assign rd_word   = mem[addr_q];
  assign commit    = ~bus.cs & (st_q == WAIT_CS) & pend_q & wen_q;
  assign bus.sdo   = sdo_q;
  assign bus.prog_din = prog_din_q;

`ifdef JTPANG_EEPROM_BUSY_EN
  logic        busy_q;
  logic [15:0] bcnt_q;

  // Ready/busy timer: armed by a commit, counts down once per clock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      bcnt_q <= 16'd0;
    end else if (commit) begin
      busy_q <= 1'b1;
      bcnt_q <= BUSY_CYCLES;
    end else if (busy_q) begin
      bcnt_q <= bcnt_q - 16'd1;
      if (bcnt_q <= 16'd1) busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
`else
  logic unused_busy_cycles;
  assign unused_busy_cycles = ^BUSY_CYCLES;
  assign busy = 1'b0;
`endif

  // Serial protocol FSM: command decode, read shifting, write collection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      sclk_l_q <= 1'b0;
      cnt_q    <= 5'd0;
      pend_q   <= 1'b0;
      all_q    <= 1'b0;
      wen_q    <= 1'b0;
      sdo_q    <= 1'b1;
    end else begin
      sclk_l_q <= bus.sclk;
      if (!bus.cs) begin
        st_q   <= IDLE;
        cnt_q  <= 5'd0;
        pend_q <= 1'b0;
        sdo_q  <= ~busy;
      end else begin
        case (st_q)
          IDLE: begin
            sdo_q <= ~busy;
            if (sclk_rise && bus.sdi && !busy) begin
              st_q  <= CMD;
              cnt_q <= 5'd0;
            end
          end
          CMD: begin
            sdo_q <= 1'b1;
            if (sclk_rise) begin
              cmd_q <= cmd_d[AW:0];
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == CMD_LAST) begin
                cnt_q  <= 5'd0;
                addr_q <= cmd_d[AW-1:0];
                all_q  <= 1'b0;
                case (cmd_d[AW+1:AW])
                  2'b10: begin
                    st_q  <= RDATA;
                    sdo_q <= 1'b0;
                  end
                  2'b01: st_q <= WDATA;
                  2'b11: begin
                    st_q   <= WAIT_CS;
                    data_q <= 16'hFFFF;
                    pend_q <= 1'b1;
                  end
                  default: begin
                    case (cmd_d[AW-1:AW-2])
                      2'b11: begin
                        wen_q <= 1'b1;
                        st_q  <= WAIT_CS;
                      end
                      2'b00: begin
                        wen_q <= 1'b0;
                        st_q  <= WAIT_CS;
                      end
                      2'b10: begin
                        st_q   <= WAIT_CS;
                        data_q <= 16'hFFFF;
                        pend_q <= 1'b1;
                        all_q  <= 1'b1;
                      end
                      default: begin
                        st_q  <= WDATA;
                        all_q <= 1'b1;
                      end
                    endcase
                  end
                endcase
              end
            end
          end
          RDATA: begin
            if (sclk_rise) begin
              sdo_q <= rd_word[~cnt_q[3:0]];
              if (cnt_q == 5'd15) begin
                cnt_q  <= 5'd0;
                addr_q <= addr_q + AW'(1);
              end else begin
                cnt_q <= cnt_q + 5'd1;
              end
            end
          end
          WDATA: begin
            sdo_q <= 1'b1;
            if (sclk_rise) begin
              data_q <= {data_q[14:0], bus.sdi};
              if (cnt_q == 5'd15) begin
                cnt_q  <= 5'd0;
                pend_q <= 1'b1;
                st_q   <= WAIT_CS;
              end else begin
                cnt_q <= cnt_q + 5'd1;
              end
            end
          end
          default: sdo_q <= 1'b1;
        endcase
      end
    end
  end

  // Serial write engine: one word, or a sweep of every word one per clock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= 1'b0;
    end else if (commit) begin
      wr_q      <= 1'b1;
      wr_all_q  <= all_q;
      wr_addr_q <= all_q ? '0 : addr_q;
      wr_data_q <= data_q;
    end else if (wr_q) begin
      if (!wr_all_q || wr_addr_q == ADDR_MAX) wr_q <= 1'b0;
      else wr_addr_q <= wr_addr_q + AW'(1);
    end
  end

  // Array writes: serial word port wins over a colliding NVRAM byte write
  always_ff @(posedge clk) begin
    if (bus.prog_we && !(wr_q && wr_addr_q == bus.prog_addr[AW:1])) begin
      if (bus.prog_addr[0]) mem[bus.prog_addr[AW:1]][15:8] <= bus.prog_data;
      else                  mem[bus.prog_addr[AW:1]][7:0]  <= bus.prog_data;
    end
    if (wr_q) mem[wr_addr_q] <= wr_data_q;
  end

  // NVRAM dump byte, one clock after the address
  always_ff @(posedge clk) begin
    if (!rst_n) prog_din_q <= 8'd0;
    else if (bus.prog_addr[0]) prog_din_q <= mem[bus.prog_addr[AW:1]][15:8];
    else                       prog_din_q <= mem[bus.prog_addr[AW:1]][7:0];
  end

endmodule
